// File: rtl/deconvolution.sv
// Recovers x0..x7 from convolution output y0..y7 and eight 4-bit taps by recurrence.
// Optional CONSISTENCY_CHECK_EN re-convolves y8..y15 against the recovered samples.
module deconvolution (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] h_flat,
  input  logic [11:0] y_data,
  input  logic        y_valid,
  output logic        y_ready,
  output logic [3:0]  x_data,
  output logic        x_valid,
  input  logic        x_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitY,
    StMac,
    StDiv,
    StOut,
    StDone
`ifdef CONSISTENCY_CHECK_EN
    ,
    StChkY,
    StChkMac
`endif
  } state_t;

  state_t      state;
  logic [3:0]  h      [8];
  logic [3:0]  x_hist [8];
  logic [3:0]  n;
  logic [3:0]  k;
  logic [11:0] acc;
  logic [11:0] y_q;
  logic [7:0]  rem;
  logic [3:0]  quo;
  logic [2:0]  div_cnt;

  logic [7:0]  prod;
  logic [12:0] resid;
  logic        resid_bad;
  logic [1:0]  bit_idx;
  logic [7:0]  dvs;
  logic        fits;
  logic [7:0]  rem_nx;
  logic [3:0]  quo_nx;

  // n indexes the sample being processed; n-k selects the history entry for tap k.
  always_comb begin
    prod      = {4'b0, h[k[2:0]]} * {4'b0, x_hist[3'(n - k)]};
    resid     = {1'b0, y_q} - {1'b0, acc};
    resid_bad = resid[12] || (resid[11:0] >= {4'b0, h[0], 4'b0});
    bit_idx   = 2'(3'd4 - div_cnt);
    dvs       = {4'b0, h[0]} << bit_idx;
    fits      = rem >= dvs;
    rem_nx    = fits ? rem - dvs : rem;
    quo_nx    = quo | (4'(fits) << bit_idx);
  end

`ifdef CONSISTENCY_CHECK_EN
  assign y_ready = (state == StWaitY) || (state == StChkY);
`else
  assign y_ready = (state == StWaitY);
`endif
  assign busy = (state != StIdle) && (state != StDone);
  assign done = (state == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      n       <= '0;
      k       <= '0;
      acc     <= '0;
      y_q     <= '0;
      rem     <= '0;
      quo     <= '0;
      div_cnt <= '0;
      x_data  <= '0;
      x_valid <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h[i]      <= '0;
        x_hist[i] <= '0;
      end
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            for (int i = 0; i < 8; i++) h[i] <= h_flat[4*i +: 4];
            n <= '0;
            if (h_flat[3:0] == 4'd0) begin
              err   <= 1'b1;
              state <= StDone;
            end else begin
              err   <= 1'b0;
              state <= StWaitY;
            end
          end
        end
        StWaitY: begin
          if (y_valid) begin
            y_q     <= y_data;
            acc     <= '0;
            k       <= 4'd1;
            quo     <= '0;
            div_cnt <= '0;
            state   <= (n == 4'd0) ? StDiv : StMac;
          end
        end
        StMac: begin
          acc <= acc + 12'(prod);
          k   <= k + 4'd1;
          if (k == n) state <= StDiv;
        end
        StDiv: begin
          // First DIV cycle screens the residual so the 4 steps cannot overflow.
          if (div_cnt == 3'd0) begin
            if (resid_bad) begin
              err   <= 1'b1;
              state <= StDone;
            end else begin
              rem     <= resid[7:0];
              div_cnt <= 3'd1;
            end
          end else begin
            rem     <= rem_nx;
            quo     <= quo_nx;
            div_cnt <= div_cnt + 3'd1;
            if (div_cnt == 3'd4) begin
              if (rem_nx != 8'd0) begin
                err   <= 1'b1;
                state <= StDone;
              end else begin
                x_data           <= quo_nx;
                x_hist[n[2:0]]   <= quo_nx;
                x_valid          <= 1'b1;
                state            <= StOut;
              end
            end
          end
        end
        StOut: begin
          if (x_ready) begin
            x_valid <= 1'b0;
            if (n == 4'd7) begin
`ifdef CONSISTENCY_CHECK_EN
              n     <= 4'd8;
              state <= StChkY;
`else
              state <= StDone;
`endif
            end else begin
              n     <= n + 4'd1;
              state <= StWaitY;
            end
          end
        end
`ifdef CONSISTENCY_CHECK_EN
        StChkY: begin
          if (y_valid) begin
            y_q   <= y_data;
            acc   <= '0;
            k     <= 4'(n - 4'd7);
            state <= StChkMac;
          end
        end
        StChkMac: begin
          // Only taps with a recovered partner x[n-k] (n-k <= 7) contribute.
          if (k <= 4'd7) begin
            acc <= acc + 12'(prod);
            k   <= k + 4'd1;
          end else begin
            if (acc != y_q) err <= 1'b1;
            if (n == 4'd15) begin
              state <= StDone;
            end else begin
              n     <= n + 4'd1;
              state <= StChkY;
            end
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_deconvolution.sv
// Directed and randomized bench for deconvolution with an arithmetic reference model.
module tb_deconvolution;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] h_flat  = '0;
  logic [11:0] y_data  = '0;
  logic        y_valid = 1'b0;
  logic        x_ready = 1'b1;
  logic        y_ready;
  logic [3:0]  x_data;
  logic        x_valid;
  logic        busy;
  logic        done;
  logic        err;

  deconvolution dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .h_flat  (h_flat),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

`ifdef CONSISTENCY_CHECK_EN
  localparam int NY = 16;
`else
  localparam int NY = 8;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int yr_cnt = 0;
  int ys    [16];
  int exp_x [8];
  int exp_cnt;
  bit exp_err;

  always @(posedge clk) begin
    if (x_valid && x_ready) hs_cnt <= hs_cnt + 1;
    if (y_ready) yr_cnt <= yr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Recurrence straight from the definition; also predicts the y8..y15 self-check.
  task automatic model(input logic [31:0] hf, input int ny);
    int hh[8];
    int s;
    for (int i = 0; i < 8; i++) hh[i] = int'(hf[4*i +: 4]);
    exp_cnt = 0;
    exp_err = 1'b0;
    if (hh[0] == 0) begin
      exp_err = 1'b1;
      return;
    end
    for (int m = 0; m < 8; m++) begin
      s = ys[m];
      for (int j = 1; j <= m; j++) s -= hh[j] * exp_x[m-j];
      if (s < 0 || (s % hh[0]) != 0 || (s / hh[0]) > 15) begin
        exp_err = 1'b1;
        return;
      end
      exp_x[m] = s / hh[0];
      exp_cnt++;
    end
    for (int m = 8; m < ny; m++) begin
      s = 0;
      for (int j = m - 7; j < 8; j++) s += hh[j] * exp_x[m-j];
      if (s != ys[m]) exp_err = 1'b1;
    end
  endtask

  task automatic set_nominal();
    int nom[16] = '{8, 23, 44, 70, 100, 133, 168, 204, 168, 133, 100, 70, 44, 23, 8, 0};
    for (int i = 0; i < 16; i++) ys[i] = nom[i];
  endtask

  task automatic start_run(input logic [31:0] hf, output int hs0);
    model(hf, NY);
    hs0 = hs_cnt;
    @(negedge clk);
    h_flat = hf;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic feed(input int i, input int hold, output bit ok);
    int t;
    int lat;
    bit seen;
    t = 0;
    while (!y_ready && !done && t < 60) begin
      @(negedge clk);
      t++;
    end
    ok = y_ready;
    if (!ok) return;
    if (hold > 0) x_ready = 1'b0;
    y_data  = 12'(ys[i]);
    y_valid = 1'b1;
    @(posedge clk);
    #1 y_valid = 1'b0;
    if (i >= 8) return;
    lat  = 0;
    seen = 1'b0;
    while (!seen && !done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = x_valid;
    end
    chk($sformatf("x%0d_present", i), 32'(seen), 32'(i < exp_cnt));
    if (!seen) begin
      ok      = 1'b0;
      x_ready = 1'b1;
      return;
    end
    chk($sformatf("x%0d_latency", i), 32'(lat), 32'(i + 5));
    chk($sformatf("x%0d_data", i), 32'(x_data), 32'(exp_x[i]));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_state", c), {29'b0, x_valid, y_ready, busy}, 32'b101);
      chk($sformatf("hold%0d_data", c), 32'(x_data), 32'(exp_x[i]));
    end
    x_ready = 1'b1;
  endtask

  task automatic finish_run(input string tag, input int hs0);
    int t;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_xcount"}, 32'(hs_cnt - hs0), 32'(exp_cnt));
  endtask

  task automatic run(input string tag, input logic [31:0] hf, input int hold_at,
                     input int hold_len);
    int hs0;
    bit ok;
    start_run(hf, hs0);
    for (int i = 0; i < NY; i++) begin
      feed(i, (i == hold_at) ? hold_len : 0, ok);
      if (!ok) break;
    end
    finish_run(tag, hs0);
  endtask

  initial begin
    int hs0;
    int yr0;
    bit ok;
    int hr[8];
    int xr[8];
    logic [31:0] hf;

    #12;
    chk("reset_outputs", {23'b0, y_ready, x_valid, x_data, busy, done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_nominal();
    run("nominal", 32'h1234_5678, -1, 0);

    yr0 = yr_cnt;
    start_run(32'h1234_5670, hs0);
    chk("zerotap_fast", {30'b0, done, err}, 32'b11);
    finish_run("zerotap", hs0);
    chk("zerotap_no_yready", 32'(yr_cnt - yr0), 32'd0);

    ys[0] = 3;
    run("inexact", 32'h0000_0002, -1, 0);

    set_nominal();
    run("backpressure", 32'h1234_5678, 2, 10);

    start_run(32'h1234_5678, hs0);
    for (int i = 0; i < 3; i++) feed(i, 0, ok);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset", {23'b0, y_ready, x_valid, x_data, busy, done, err}, 32'd0);
    hs0 = hs_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {28'b0, y_ready, x_valid, busy, done}, 32'd0);
    chk("post_reset_no_x", 32'(hs_cnt - hs0), 32'd0);
    run("after_reset", 32'h1234_5678, -1, 0);

`ifdef CONSISTENCY_CHECK_EN
    set_nominal();
    ys[8] = 169;
    run("chk_mismatch", 32'h1234_5678, -1, 0);
`endif

    for (int r = 0; r < 6; r++) begin
      hr[0] = $urandom_range(15, 1);
      for (int i = 1; i < 8; i++) hr[i] = $urandom_range(15, 0);
      for (int i = 0; i < 8; i++) xr[i] = $urandom_range(15, 0);
      hf = '0;
      for (int i = 0; i < 8; i++) hf[4*i +: 4] = 4'(hr[i]);
      for (int m = 0; m < 16; m++) begin
        ys[m] = 0;
        for (int j = 0; j < 8; j++) if (m - j >= 0 && m - j < 8) ys[m] += hr[j] * xr[m-j];
      end
      if (r % 2 == 1) begin
        int idx;
        idx = $urandom_range(7, 0);
        ys[idx] = ys[idx] + 1;
      end
      run($sformatf("random%0d", r), hf, -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deconvolution.md
DECONVOLUTION -- requirements
Module: deconvolution

Interface
REQ-001 The block SHALL expose these ports; clock and reset first, all unsigned:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begins a run; sampled only in IDLE or DONE
- h_flat  in  32  taps h0..h7, h0 in bits [3:0], hk in [4k+3:4k]; latched on accepted start
- y_data  in  12  convolution output sample y[n]
- y_valid  in  1  y_data valid
- y_ready  out  1  block accepts y_data
- x_data  out  4  recovered input sample x[n]
- x_valid  out  1  x_data valid
- x_ready  in  1  consumer accepts x_data
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- err  out  1  sticky error for the current run, cleared on accepted start

Function
REQ-002 The block SHALL recover x0..x7 from y0..y7 by recurrence: x[n] = (y[n] - sum over k=1..n of h[k]*x[n-k]) / h0.
REQ-003 FSM states SHALL be IDLE, WAIT_Y, MAC, DIV, OUT and DONE, plus CHK_Y and CHK_MAC when CONSISTENCY_CHECK_EN is defined.
REQ-004 IDLE/DONE + start=1 SHALL latch h_flat, clear err and the sample index n, and go to WAIT_Y; if latched h0=0 the next state SHALL be DONE with err=1 instead.
REQ-005 y_ready SHALL be 1 only in WAIT_Y (and CHK_Y); a sample is accepted on a rising edge with y_valid=1 and y_ready=1.
REQ-006 MAC SHALL perform one h[k]*x[n-k] accumulation per cycle, n cycles in total; for n=0 the FSM SHALL skip MAC and go directly to DIV.
REQ-007 The accumulator SHALL be at least 12 bits wide. A residual y[n]-sum below 0 SHALL set err and go to DONE.
REQ-008 DIV SHALL run a 4-cycle restoring division of the residual by h0.
- A nonzero remainder, or a quotient of 16 or more, SHALL set err and go to DONE.
- Otherwise the quotient is stored as x[n] and the FSM goes to OUT.
REQ-009 OUT SHALL drive x_valid=1 and x_data=x[n], both stable, until x_ready=1; then n increments and the FSM goes to WAIT_Y, or to DONE after n=7.
REQ-010 Latency SHALL be exactly n+5 rising edges from the y-accept edge to the first cycle with x_valid=1.
REQ-011 start SHALL be ignored while busy=1. When an error occurs, no further x_valid SHALL be produced for that run.

Reset
REQ-012 With rst_n=0 the block SHALL immediately and asynchronously enter IDLE and clear all of the following:
- outputs y_ready, x_valid, x_data, busy, done and err
- the x history, the taps and the accumulator
REQ-013 Reset asserted mid-run SHALL abort the run with no x_valid afterwards; after rst_n rises the block SHALL wait for a new start.

Configuration
REQ-014 Macro CONSISTENCY_CHECK_EN: when defined, the run SHALL continue after x7 instead of going to DONE.
- It accepts y8..y15 through CHK_Y.
- For each sample it computes the sum over valid k of h[k]*x[m-k] in CHK_MAC.
- Any mismatch with the accepted sample SHALL set err; the check for y15 requires y15=0.
- The FSM goes to DONE after y15.
REQ-015 Without CONSISTENCY_CHECK_EN the block SHALL go to DONE after x7, and the CHK states and their logic SHALL be absent.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Nominal: h=8,7,6,5,4,3,2,1 and y0..y7 = 8,23,44,70,100,133,168,204 -> x_data 1..8 in order, err=0, done=1.
- Zero tap: start with h0=0 -> done=1 and err=1 within 2 cycles; x_valid never asserted; y_ready never asserted.
- Inexact division: h0=2 with other taps 0, and y0=3 -> err=1, DONE, no x_valid.
- Backpressure: nominal stimulus with x_ready held 0 for 10 cycles at x2 -> x_valid=1 and x_data=3 held constant throughout; y_ready=0 during the hold.
- Reset mid-run: rst_n pulsed low after x2 is accepted -> all outputs 0 in the same cycle; then a new start with nominal data yields 1..8.
- With CONSISTENCY_CHECK_EN: nominal data followed by y8..y15 = 168,133,100,70,44,23,8,0 -> err=0; the same sequence with y8=169 -> err=1.
